// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder: 2-FF synchronisers, per-channel debounce,
// step decode to one-cycle inc/dec pulses. Define ROTARY_DETENT_EN for one pulse per detent.
`timescale 1ns/1ps
module rotary_decoder #(
  parameter int unsigned DEBOUNCE_TIME = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic inc_pulse,
  output logic dec_pulse
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_TIME + 1);
  localparam int unsigned PRIME_W = $clog2(DEBOUNCE_TIME + 3);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(DEBOUNCE_TIME + 1);

  typedef enum logic {PRIMING, RUNNING} phase_t;

  phase_t             phase, phase_next;
  logic [PRIME_W-1:0] prime_cnt, prime_cnt_next;
  logic               a_meta, a_sync, b_meta, b_sync;
  logic               deb_a, deb_b, deb_a_next, deb_b_next;
  logic [CNT_W-1:0]   cnt_a, cnt_b, cnt_a_next, cnt_b_next;
  logic [1:0]         prev_ab, prev_ab_next, cur_ab;
  logic               step_cw, step_ccw;
  logic               inc_next, dec_next;
`ifdef ROTARY_DETENT_EN
  logic signed [2:0]  acc, acc_next;
  logic [3:0]         delta, sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
    end else begin
      a_meta <= enc_a;
      a_sync <= a_meta;
      b_meta <= enc_b;
      b_sync <= b_meta;
    end
  end

  assign cur_ab = {deb_a, deb_b};

  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_cw  = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_ccw = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    phase_next     = phase;
    prime_cnt_next = prime_cnt;
    deb_a_next     = deb_a;
    deb_b_next     = deb_b;
    cnt_a_next     = cnt_a;
    cnt_b_next     = cnt_b;
    prev_ab_next   = cur_ab;
    inc_next       = 1'b0;
    dec_next       = 1'b0;
`ifdef ROTARY_DETENT_EN
    acc_next       = acc;
    delta          = step_cw ? 4'b0001 : (step_ccw ? 4'b1111 : 4'b0000);
    sum            = {acc[2], acc} + delta;
`endif
    case (phase)
      PRIMING: begin
        // Follow the inputs directly so a resting non-00 position is adopted silently.
        deb_a_next   = a_sync;
        deb_b_next   = b_sync;
        cnt_a_next   = '0;
        cnt_b_next   = '0;
        prev_ab_next = {a_sync, b_sync};
`ifdef ROTARY_DETENT_EN
        acc_next     = '0;
`endif
        if (prime_cnt == PRIME_LAST) begin
          phase_next = RUNNING;
        end else begin
          prime_cnt_next = prime_cnt + PRIME_W'(1);
        end
      end
      RUNNING: begin
        if (a_sync == deb_a) begin
          cnt_a_next = '0;
        end else if (cnt_a == CNT_LAST) begin
          deb_a_next = a_sync;
          cnt_a_next = '0;
        end else begin
          cnt_a_next = cnt_a + CNT_W'(1);
        end

        if (b_sync == deb_b) begin
          cnt_b_next = '0;
        end else if (cnt_b == CNT_LAST) begin
          deb_b_next = b_sync;
          cnt_b_next = '0;
        end else begin
          cnt_b_next = cnt_b + CNT_W'(1);
        end

`ifdef ROTARY_DETENT_EN
        // Sum is one bit wider so the completing +/-4 step is visible before wrap.
        if (cur_ab == 2'b00 && prev_ab != 2'b00) begin
          inc_next = (sum == 4'b0100);
          dec_next = (sum == 4'b1100);
          acc_next = '0;
        end else begin
          acc_next = signed'(sum[2:0]);
        end
`else
        inc_next = step_cw;
        dec_next = step_ccw;
`endif
      end
      default: phase_next = PRIMING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PRIMING;
      prime_cnt <= '0;
      deb_a     <= 1'b0;
      deb_b     <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      prev_ab   <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
`ifdef ROTARY_DETENT_EN
      acc       <= '0;
`endif
    end else begin
      phase     <= phase_next;
      prime_cnt <= prime_cnt_next;
      deb_a     <= deb_a_next;
      deb_b     <= deb_b_next;
      cnt_a     <= cnt_a_next;
      cnt_b     <= cnt_b_next;
      prev_ab   <= prev_ab_next;
      inc_pulse <= inc_next;
      dec_pulse <= dec_next;
`ifdef ROTARY_DETENT_EN
      acc       <= acc_next;
`endif
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_TIME=3: table of held AB positions
// with expected pulse counts, plus glitch, latency and reset sequences.
`timescale 1ns/1ps
module tb_rotary_decoder;

`ifdef ROTARY_DETENT_EN
  localparam bit DETENT = 1'b1;
`else
  localparam bit DETENT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enc_a, enc_b, inc_pulse, dec_pulse;

  always #5 clk = ~clk;

  rotary_decoder #(.DEBOUNCE_TIME(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse)
  );

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         q_inc;
    int         q_dec;
    int         d_inc;
    int         d_dec;
  } vec_t;

  vec_t vecs [12];
  int   n_vec = 0;
  int   n_bad = 0;
  int   inc_cnt = 0;
  int   dec_cnt = 0;
  bit   both_seen = 1'b0;
  int   lat;

  task automatic tick();
    @(posedge clk);
    #1;
    if (inc_pulse === 1'b1) inc_cnt++;
    if (dec_pulse === 1'b1) dec_cnt++;
    if (inc_pulse === 1'b1 && dec_pulse === 1'b1) both_seen = 1'b1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic clear_counts();
    inc_cnt = 0;
    dec_cnt = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //           ab     hold q_inc q_dec d_inc d_dec
    vecs[0]  = '{2'b10, 12,  1,    0,    0,    0};
    vecs[1]  = '{2'b11, 12,  1,    0,    0,    0};
    vecs[2]  = '{2'b01, 12,  1,    0,    0,    0};
    vecs[3]  = '{2'b00, 12,  1,    0,    1,    0};
    vecs[4]  = '{2'b01, 12,  0,    1,    0,    0};
    vecs[5]  = '{2'b11, 12,  0,    1,    0,    0};
    vecs[6]  = '{2'b10, 12,  0,    1,    0,    0};
    vecs[7]  = '{2'b00, 12,  0,    1,    0,    1};
    vecs[8]  = '{2'b11, 12,  0,    0,    0,    0};
    vecs[9]  = '{2'b00, 12,  0,    0,    0,    0};
    vecs[10] = '{2'b10, 12,  1,    0,    0,    0};
    vecs[11] = '{2'b00, 12,  0,    1,    0,    0};

    rst = 1'b1;
    drive(2'b00);
    hold(2);
    check("reset_inc", int'(inc_pulse), 0);
    check("reset_dec", int'(dec_pulse), 0);
    rst = 1'b0;
    hold(10);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ab);
      clear_counts();
      hold(vecs[i].hold);
      check($sformatf("vec%0d_inc", i), inc_cnt, DETENT ? vecs[i].d_inc : vecs[i].q_inc);
      check($sformatf("vec%0d_dec", i), dec_cnt, DETENT ? vecs[i].d_dec : vecs[i].q_dec);
    end

    // Two-cycle glitch on A is shorter than the debounce window.
    clear_counts();
    drive(2'b10);
    hold(2);
    drive(2'b00);
    hold(12);
    check("glitch_inc", inc_cnt, 0);
    check("glitch_dec", dec_cnt, 0);
    check("glitch_deb_a", int'(dut.deb_a), 0);
    check("glitch_deb_b", int'(dut.deb_b), 0);

    // Three-cycle excursion equals the debounce window and is accepted.
    clear_counts();
    drive(2'b10);
    hold(3);
    drive(2'b00);
    hold(12);
    check("edge3_inc", inc_cnt, DETENT ? 0 : 1);
    check("edge3_dec", dec_cnt, DETENT ? 0 : 1);

    // Edge-to-pulse latency: 2 sync + 3 debounce + 1 output register.
    lat = 0;
    drive(2'b10);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (inc_pulse === 1'b1 && lat == 0) lat = k;
    end
    check("latency", lat, DETENT ? 0 : 6);
    drive(2'b00);
    hold(12);

    // Encoder resting at 10 through reset must not pulse.
    drive(2'b10);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    clear_counts();
    hold(20);
    check("rest10_inc", inc_cnt, 0);
    check("rest10_dec", dec_cnt, 0);
    drive(2'b11);
    clear_counts();
    hold(12);
    check("rest10_step_inc", inc_cnt, DETENT ? 0 : 1);
    check("rest10_step_dec", dec_cnt, 0);
    drive(2'b01);
    hold(12);
    drive(2'b00);
    hold(12);

    // Reset while the 10->11 step is still debouncing.
    drive(2'b10);
    hold(12);
    drive(2'b11);
    hold(3);
    rst = 1'b1;
    tick();
    check("midrst_inc_out", int'(inc_pulse), 0);
    check("midrst_dec_out", int'(dec_pulse), 0);
    tick();
    rst = 1'b0;
    clear_counts();
    hold(20);
    check("midrst_inc", inc_cnt, 0);
    check("midrst_dec", dec_cnt, 0);

    check("exclusive", int'(both_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter DEBOUNCE_TIME, default 1000, stable-cycle count a synchronised input must hold before acceptance; legal range >= 1.
REQ-002 clk  input  1  single clock; all logic rising-edge triggered.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-005 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-006 inc_pulse  output  1  one-cycle pulse per accepted clockwise (A-leads-B) step.
REQ-007 dec_pulse  output  1  one-cycle pulse per accepted counter-clockwise (B-leads-A) step.

Function
REQ-008 Each input SHALL pass a dedicated 2-FF synchroniser; no other logic reads enc_a/enc_b.
REQ-009 Each channel SHALL have a debounce counter of width $clog2(DEBOUNCE_TIME+1), cleared whenever the synchronised value equals the debounced value.
REQ-010 Debounced value SHALL take the synchronised value once the two have differed for DEBOUNCE_TIME consecutive cycles, and the counter then clears; a glitch shorter than DEBOUNCE_TIME cycles SHALL leave the debounced value unchanged.
REQ-011 Decoder SHALL register previous debounced state {A,B} and compare with current state each cycle.
REQ-012 CW transitions 00->10, 10->11, 11->01, 01->00 SHALL count as +1 step; CCW transitions 00->01, 01->11, 11->10, 10->00 SHALL count as -1 step.
REQ-013 No change, or both bits changing in one cycle (invalid), SHALL produce no step and no pulse; previous state still updates.
REQ-014 Outputs SHALL be registered; pulse asserted exactly one cycle after the debounced state change, width one cycle.
REQ-015 inc_pulse and dec_pulse SHALL never be asserted in the same cycle.
REQ-016 Latency from a stable input edge to pulse SHALL be 2 (sync) + DEBOUNCE_TIME + 1 cycles, within +/-1 cycle for edge-to-clock phase.
REQ-017 Consecutive valid steps SHALL each produce their own pulse; back-to-back steps are limited only by debounce timing.

Reset
REQ-018 While rst=1: synchroniser flops, debounced values, previous state and debounce counters SHALL clear to 0; inc_pulse=dec_pulse=0 on the cycle after rst is sampled high.
REQ-019 A primed flag SHALL clear on reset; until DEBOUNCE_TIME+2 cycles after reset release, debounced values and previous state track the synchronised inputs directly and no pulses are issued, so an encoder resting at a non-00 position causes no spurious pulse.
REQ-020 Reset asserted mid-sequence SHALL abort any pending debounce or partial step; no pulse is owed afterwards.

Configuration
REQ-021 Macro ROTARY_DETENT_EN: when undefined, one pulse per valid quarter step (4 per detent cycle).
REQ-022 When ROTARY_DETENT_EN is defined, a signed 3-bit sub-step accumulator SHALL sum steps and clear on reset; entering state 00 with accumulator +4 gives one inc_pulse, with -4 one dec_pulse; entering 00 SHALL always clear the accumulator.

Verification
REQ-023 DEBOUNCE_TIME=3, hold AB 00,10,11,01,00 for 12 cycles each -> inc_pulse count 4 (1 with ROTARY_DETENT_EN), dec_pulse count 0.
REQ-024 DEBOUNCE_TIME=3, hold AB 00,01,11,10,00 for 12 cycles each -> dec_pulse count 4 (1 with macro), inc_pulse count 0.
REQ-025 DEBOUNCE_TIME=3, from 00 pulse enc_a high for 2 cycles -> no pulses, debounced state stays 00.
REQ-026 DEBOUNCE_TIME=3, from 00 drive AB=11 in one step and hold 12 cycles -> no pulses.
REQ-027 Hold AB=10 across reset and 20 cycles after release -> no pulses; then 10->11 -> one inc_pulse (macro undefined).
REQ-028 Assert rst mid-CW sequence at AB=11 -> outputs 0 next cycle; no pulse within 20 cycles of release with inputs held.
